// File: rtl/pdu_top.sv
// Board-level debug unit: hex entry from switches, run/step control of a 32-bit
// run counter with breakpoint, and an 8-digit multiplexed 7-segment readout.
module pdu_top #(
  parameter int unsigned SCAN_DIV = 17
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        step,
  input  logic        cont,
  input  logic        chk,
  input  logic        ent,
  input  logic        del,
  input  logic [15:0] hd,
  output logic        pause,
  output logic [15:0] led,
  output logic [7:0]  an,
  output logic [7:0]  seg
);

  typedef enum logic {StPause, StRun} state_e;

  // Input bit layout: [0] step, [1] cont, [2] chk, [3] ent, [4] del, [20:5] hd
  logic [20:0] raw, sync1_q, sync2_q, sync3_q, rise;

  state_e        state_q, state_d;
  logic [31:0]   buf_q, buf_d;
  logic [31:0]   bp_q, bp_d;
  logic [31:0]   cnt_q, cnt_d;
  logic [1:0]    sel_q, sel_d;
  logic [SCAN_DIV+2:0] refresh_q;

  logic [3:0]  digit;
  logic        hd_any;
  logic [31:0] cnt_inc;
  logic [31:0] value;
  logic [2:0]  idx;
  logic [3:0]  nib;

  assign raw = {hd, del, ent, chk, cont, step};

  // Two-flop synchroniser plus one extra stage for rising-edge detection
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync1_q <= '0;
      sync2_q <= '0;
      sync3_q <= '0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
    end
  end

  assign rise   = sync2_q & ~sync3_q;
  assign hd_any = |rise[20:5];

  // Lowest switch index wins when several rise together
  always_comb begin
    digit = '0;
    for (int i = 15; i >= 0; i--) begin
      if (rise[5+i]) digit = 4'(i);
    end
  end

  assign cnt_inc = cnt_q + 32'd1;

  // Next-state: one winning button per cycle, counter runs independently in RUN
  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    bp_d    = bp_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    if (rise[3]) begin
      if (state_q == StPause) begin
        bp_d  = buf_q;
        buf_d = '0;
      end else begin
        state_d = StPause;
      end
    end else if (rise[4]) begin
      buf_d = buf_q >> 4;
    end else if (hd_any) begin
      buf_d = {buf_q[27:0], digit};
    end else if (state_q == StPause) begin
      if (rise[0]) begin
        cnt_d = cnt_inc;
      end else if (rise[1]) begin
        state_d = StRun;
      end else if (rise[2]) begin
        sel_d = (sel_q == 2'd2) ? 2'd0 : sel_q + 2'd1;
      end
    end
    // Stop in RUN suppresses that cycle's increment
    if (state_q == StRun && !rise[3]) begin
      cnt_d = cnt_inc;
      if (bp_q != '0 && cnt_inc == bp_q) state_d = StPause;
    end
  end

  // Architectural registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= StPause;
      buf_q   <= '0;
      bp_q    <= '0;
      cnt_q   <= '0;
      sel_q   <= '0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      bp_q    <= bp_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
    end
  end

  // Free-running scan counter for digit multiplexing
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) refresh_q <= '0;
    else       refresh_q <= refresh_q + 1'b1;
  end

  assign idx = refresh_q[SCAN_DIV+2:SCAN_DIV];

  // Display source select and digit extraction
  always_comb begin
    case (sel_q)
      2'd1:    value = cnt_q;
      2'd2:    value = bp_q;
      default: value = buf_q;
    endcase
    nib = value[{idx, 2'b00} +: 4];
    an  = ~(8'd1 << idx);
  end

  // Hex font, active low, decimal point off
  always_comb begin
    seg = 8'hFF;
    case (nib)
      4'h0: seg = 8'hC0;
      4'h1: seg = 8'hF9;
      4'h2: seg = 8'hA4;
      4'h3: seg = 8'hB0;
      4'h4: seg = 8'h99;
      4'h5: seg = 8'h92;
      4'h6: seg = 8'h82;
      4'h7: seg = 8'hF8;
      4'h8: seg = 8'h80;
      4'h9: seg = 8'h90;
      4'hA: seg = 8'h88;
      4'hB: seg = 8'h83;
      4'hC: seg = 8'hC6;
      4'hD: seg = 8'hA1;
      4'hE: seg = 8'h86;
      4'hF: seg = 8'h8E;
      default: seg = 8'hFF;
    endcase
  end

  assign pause = (state_q == StPause);
  assign led   = cnt_q[15:0];

endmodule

// File: tb/tb_pdu_top.sv
// Self-checking bench for pdu_top: randomized entry plus directed run/step/breakpoint
// scenarios, checked against an abstract register-level model of the debug unit.
module tb_pdu_top;

  localparam int BStep = 0;
  localparam int BCont = 1;
  localparam int BChk  = 2;
  localparam int BEnt  = 3;
  localparam int BDel  = 4;

  localparam logic [7:0] FONT [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                      8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  logic        clk = 1'b0;
  logic        rstn;
  logic [4:0]  btn;
  logic [15:0] hd;
  logic        pause;
  logic [15:0] led;
  logic [7:0]  an;
  logic [7:0]  seg;

  int checks = 0;
  int errors = 0;

  // Abstract model state
  logic [31:0] m_buf, m_bp, m_cnt;
  int          m_sel;
  logic [2:0]  m_scan;

  pdu_top #(.SCAN_DIV(0)) dut (
    .clk   (clk),
    .rstn  (rstn),
    .step  (btn[BStep]),
    .cont  (btn[BCont]),
    .chk   (btn[BChk]),
    .ent   (btn[BEnt]),
    .del   (btn[BDel]),
    .hd    (hd),
    .pause (pause),
    .led   (led),
    .an    (an),
    .seg   (seg)
  );

  always #5 clk = ~clk;

  // One digit per clock with SCAN_DIV=0: digit index is the clock count since reset, mod 8
  always @(posedge clk or negedge rstn) begin
    if (!rstn) m_scan <= 3'd0;
    else       m_scan <= m_scan + 3'd1;
  end

  initial begin
    #(10 * 90000);
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic logic [31:0] disp_exp();
    case (m_sel)
      1:       return m_cnt;
      2:       return m_bp;
      default: return m_buf;
    endcase
  endfunction

  // Called at a negedge; raises inputs for one cycle, returns at the negedge right after
  // the action has taken effect (three rising edges later).
  task automatic press(input logic [4:0] b, input logic [15:0] h);
    btn = b;
    hd  = h;
    @(negedge clk);
    btn = '0;
    hd  = '0;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic press_hd_model(input logic [15:0] h);
    press(5'd0, h);
    for (int i = 0; i < 16; i++) begin
      if (h[i]) begin
        m_buf = (m_buf << 4) | 32'(i);
        break;
      end
    end
  endtask

  // Scans all eight digits, decoding the font; bad counts wrong anodes or unknown glyphs
  task automatic read_display(output logic [31:0] v, output int bad);
    v   = '0;
    bad = 0;
    for (int k = 0; k < 8; k++) begin
      logic found;
      found = 1'b0;
      if (an !== ~(8'd1 << m_scan)) bad++;
      for (int n = 0; n < 16; n++) begin
        if (seg === FONT[n]) begin
          v[{m_scan, 2'b00} +: 4] = 4'(n);
          found = 1'b1;
        end
      end
      if (!found) bad++;
      @(negedge clk);
    end
  endtask

  task automatic set_sel(input int t);
    while (m_sel != t) begin
      press(5'd1 << BChk, '0);
      m_sel = (m_sel + 1) % 3;
    end
  endtask

  task automatic model_reset();
    m_buf = '0;
    m_bp  = '0;
    m_cnt = '0;
    m_sel = 0;
  endtask

  task automatic test_reset();
    logic [31:0] v;
    int bad;
    rstn = 1'b0;
    btn  = '0;
    hd   = '0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (pause !== 1'b1) begin errors++; $display("FAIL reset_pause got %h want 1", pause); end
    checks++;
    if (led !== 16'h0) begin errors++; $display("FAIL reset_led got %h want 0000", led); end
    checks++;
    if (an !== 8'hFE) begin errors++; $display("FAIL reset_an got %h want FE", an); end
    checks++;
    if (seg !== 8'hC0) begin errors++; $display("FAIL reset_seg got %h want C0", seg); end
    rstn = 1'b1;
    read_display(v, bad);
    checks++;
    if (v !== 32'h0 || bad != 0) begin
      errors++; $display("FAIL reset_display got %h bad %0d want 00000000", v, bad);
    end
  endtask

  task automatic test_step();
    for (int i = 0; i < 3; i++) begin
      press(5'd1 << BStep, '0);
      m_cnt++;
    end
    checks++;
    if (led !== m_cnt[15:0] || pause !== 1'b1) begin
      errors++; $display("FAIL step_x3 got led %h pause %b want %h 1", led, pause, m_cnt[15:0]);
    end
  endtask

  task automatic test_entry();
    logic [31:0] v;
    int bad;
    press_hd_model(16'h0008);
    press_hd_model(16'h0001);
    press_hd_model(16'h0100);
    press_hd_model(16'h0001);
    read_display(v, bad);
    checks++;
    if (v !== 32'h00003080 || bad != 0) begin
      errors++; $display("FAIL entry_3080 got %h bad %0d want 00003080", v, bad);
    end
    press(5'd1 << BDel, '0);
    m_buf = m_buf >> 4;
    read_display(v, bad);
    checks++;
    if (v !== 32'h00000308 || bad != 0) begin
      errors++; $display("FAIL entry_del got %h bad %0d want 00000308", v, bad);
    end
    // del and a digit in the same cycle: del wins
    press(5'd1 << BDel, 16'h0020);
    m_buf = m_buf >> 4;
    press_hd_model(16'h0A40);
    read_display(v, bad);
    checks++;
    if (v !== disp_exp() || bad != 0) begin
      errors++; $display("FAIL entry_prio got %h bad %0d want %h", v, bad, disp_exp());
    end
    for (int it = 0; it < 14; it++) begin
      if ($urandom_range(0, 3) == 0) begin
        press(5'd1 << BDel, '0);
        m_buf = m_buf >> 4;
      end else begin
        logic [15:0] h;
        h = 16'($urandom);
        if (h == 0) h = 16'h8000;
        press_hd_model(h);
      end
      read_display(v, bad);
      checks++;
      if (v !== disp_exp() || bad != 0) begin
        errors++; $display("FAIL entry_rand%0d got %h bad %0d want %h", it, v, bad, disp_exp());
      end
    end
  endtask

  task automatic test_breakpoint();
    logic [31:0] v;
    int bad;
    int waited;
    press(5'd1 << BEnt, '0);
    m_bp  = m_buf;
    m_buf = '0;
    press_hd_model(16'h0008);
    press_hd_model(16'h0001);
    press_hd_model(16'h0100);
    press_hd_model(16'h0001);
    press(5'd1 << BEnt, '0);
    m_bp  = m_buf;
    m_buf = '0;
    set_sel(2);
    read_display(v, bad);
    checks++;
    if (v !== 32'h00003080 || bad != 0) begin
      errors++; $display("FAIL bp_value got %h bad %0d want 00003080", v, bad);
    end
    set_sel(0);
    read_display(v, bad);
    checks++;
    if (v !== 32'h0 || bad != 0) begin
      errors++; $display("FAIL bp_buf_clear got %h bad %0d want 00000000", v, bad);
    end
    press(5'd1 << BCont, '0);
    checks++;
    if (pause !== 1'b0) begin errors++; $display("FAIL bp_run got pause %b want 0", pause); end
    for (int k = 1; k <= 4; k++) begin
      logic [31:0] e;
      @(negedge clk);
      e = m_cnt + 32'(k);
      checks++;
      if (led !== e[15:0]) begin
        errors++; $display("FAIL bp_count%0d got %h want %h", k, led, e[15:0]);
      end
    end
    waited = 0;
    while (pause !== 1'b1 && waited < 20000) begin
      @(negedge clk);
      waited++;
    end
    checks++;
    if (pause !== 1'b1) begin errors++; $display("FAIL bp_halt_timeout got pause %b want 1", pause); end
    m_cnt = 32'h3080;
    repeat (5) @(negedge clk);
    checks++;
    if (led !== 16'h3080 || pause !== 1'b1) begin
      errors++; $display("FAIL bp_halt_value got led %h pause %b want 3080 1", led, pause);
    end
    set_sel(1);
    read_display(v, bad);
    checks++;
    if (v !== m_cnt || bad != 0) begin
      errors++; $display("FAIL bp_cnt_display got %h bad %0d want %h", v, bad, m_cnt);
    end
  endtask

  task automatic test_free_run();
    logic [31:0] v;
    int bad;
    logic [15:0] frozen;
    set_sel(0);
    // buf is zero here, so this clears the breakpoint
    press(5'd1 << BEnt, '0);
    m_bp  = m_buf;
    m_buf = '0;
    press(5'd1 << BCont, '0);
    press_hd_model(16'h0020);
    repeat (162) @(negedge clk);
    press(5'd1 << BEnt, '0);
    m_cnt = m_cnt + 32'd167;
    checks++;
    if (pause !== 1'b1 || led !== m_cnt[15:0]) begin
      errors++; $display("FAIL run_stop got led %h pause %b want %h 1", led, pause, m_cnt[15:0]);
    end
    frozen = led;
    repeat (6) @(negedge clk);
    checks++;
    if (led !== m_cnt[15:0]) begin
      errors++; $display("FAIL run_frozen got %h want %h (seen %h)", led, m_cnt[15:0], frozen);
    end
    read_display(v, bad);
    checks++;
    if (v !== m_buf || bad != 0) begin
      errors++; $display("FAIL run_buf_kept got %h bad %0d want %h", v, bad, m_buf);
    end
    set_sel(2);
    read_display(v, bad);
    checks++;
    if (v !== 32'h0 || bad != 0) begin
      errors++; $display("FAIL run_bp_kept got %h bad %0d want 00000000", v, bad);
    end
    for (int i = 0; i < 3; i++) press_hd_model(16'd1 << $urandom_range(0, 15));
    press(5'd1 << BEnt, '0);
    m_bp  = m_buf;
    m_buf = '0;
    read_display(v, bad);
    checks++;
    if (v !== m_bp || bad != 0) begin
      errors++; $display("FAIL second_ent_bp got %h bad %0d want %h", v, bad, m_bp);
    end
  endtask

  task automatic test_step_in_run();
    logic [31:0] v;
    int bad;
    // Breakpoint is far ahead of the counter, so it cannot trigger here
    press(5'd1 << BCont, '0);
    press(5'd1 << BStep, '0);
    press(5'd1 << BChk, '0);
    press(5'd1 << BEnt, '0);
    m_cnt = m_cnt + 32'd8;
    checks++;
    if (led !== m_cnt[15:0] || pause !== 1'b1) begin
      errors++; $display("FAIL run_ignore got led %h pause %b want %h 1", led, pause, m_cnt[15:0]);
    end
    read_display(v, bad);
    checks++;
    if (v !== disp_exp() || bad != 0) begin
      errors++; $display("FAIL run_sel_kept got %h bad %0d want %h", v, bad, disp_exp());
    end
  endtask

  task automatic test_chk();
    logic [31:0] v;
    int bad;
    set_sel(0);
    press_hd_model(16'h4000);
    press_hd_model(16'h0004);
    for (int k = 0; k < 3; k++) begin
      press(5'd1 << BChk, '0);
      m_sel = (m_sel + 1) % 3;
      read_display(v, bad);
      checks++;
      if (v !== disp_exp() || bad != 0) begin
        errors++; $display("FAIL chk_sel%0d got %h bad %0d want %h", m_sel, v, bad, disp_exp());
      end
    end
  endtask

  task automatic test_reset_run();
    logic [31:0] v;
    int bad;
    press(5'd1 << BCont, '0);
    repeat (10) @(negedge clk);
    rstn = 1'b0;
    #1;
    model_reset();
    checks++;
    if (pause !== 1'b1 || led !== 16'h0) begin
      errors++; $display("FAIL reset_run got led %h pause %b want 0000 1", led, pause);
    end
    @(negedge clk);
    rstn = 1'b1;
    read_display(v, bad);
    checks++;
    if (v !== 32'h0 || bad != 0) begin
      errors++; $display("FAIL reset_run_buf got %h bad %0d want 00000000", v, bad);
    end
    repeat (4) @(negedge clk);
    checks++;
    if (pause !== 1'b1 || led !== 16'h0) begin
      errors++; $display("FAIL reset_run_idle got led %h pause %b want 0000 1", led, pause);
    end
  endtask

  initial begin
    test_reset();
    test_step();
    test_entry();
    test_breakpoint();
    test_free_run();
    test_step_in_run();
    test_chk();
    test_reset_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
